spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
Sequences register accesses behind the SPI slave byte interface.
- Consumes received bytes: command byte first, then data bytes.
- Drives a single-master 8-bit register bus with a req/ack handshake and a timeout.
- Supplies read data back to the SPI transmit path.
- Sits between the SPI slave and the register file; frame boundaries come from the raw chip-select.

Parameters:
ADDR_W, 7, register address width (1..7); taken from command bits [ADDR_W-1:0].
AUTO_INC, 1, 1 = address increments after every data byte; 0 = address fixed for the frame.
TIMEOUT, 15, max cycles reg_req may stay high without reg_ack before the access is aborted (1..255).
DUMMY, 8'hFF, tx_data value when no valid read data is available.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  asynchronous, active-high reset.
cs  in  1  raw SPI chip-select, active low; synchronised internally.
rx_valid  in  1  one-cycle pulse: rx_data holds a complete received byte.
rx_data  in  8  received byte.
tx_ready  out  1  tx_data is valid for transmission.
tx_data  out  8  byte to transmit on MISO.
reg_req  out  1  bus request; held until ack or timeout.
reg_we  out  1  1 = write, 0 = read; stable while reg_req is high.
reg_addr  out  ADDR_W  bus address.
reg_wdata  out  8  write data.
reg_rdata  in  8  read data; sampled in the reg_ack cycle.
reg_ack  in  1  access complete; may assert in the first reg_req cycle.
busy  out  1  high whenever state != IDLE.
err  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset values (async): all outputs 0 except tx_data = DUMMY; state = IDLE; cs sync flops = 1.
- cs passes through a 2-flop synchroniser to cs_s.
  - frame_start = cs_s falling; frame_end = cs_s rising.
- States:
  - IDLE: tx_ready = 0, tx_data = DUMMY. frame_start -> CMD.
  - CMD: on rx_valid, latch rw = rx_data[7] and addr = rx_data[ADDR_W-1:0]. rw = 1 -> RD_REQ; rw = 0 -> DATA.
  - RD_REQ: reg_req = 1, reg_we = 0, reg_addr = addr.
    - On reg_ack: tx_data <= reg_rdata, tx_ready <= 1, addr += AUTO_INC -> DATA.
  - WR_REQ: reg_req = 1, reg_we = 1, reg_wdata = latched byte.
    - On reg_ack: addr += AUTO_INC -> DATA.
  - DATA: on rx_valid: write frame -> latch rx_data, go to WR_REQ; read frame -> RD_REQ (prefetch the next address).
- Latency: reg_req asserts the cycle after the triggering rx_valid. reg_req and tx_data update the cycle after reg_ack. Zero-wait ack gives a 2-cycle bus slot.
- Timeout: counter clears on entry to RD_REQ/WR_REQ and increments each cycle reg_ack is low. On reaching TIMEOUT:
  - drop reg_req, set err, treat as completed;
  - reads return DUMMY with tx_ready = 1;
  - address still increments.
- Address wrap: 2^ADDR_W-1 + 1 -> 0, no error.
- Overrun: rx_valid while in RD_REQ/WR_REQ drops the byte, sets err, and leaves the current access untouched.
- frame_end:
  - in CMD/DATA -> IDLE next cycle, tx_ready = 0;
  - in RD_REQ/WR_REQ -> set drain flag, finish the access (ack or timeout), then -> IDLE without updating tx_data.
- frame_end and rx_valid in the same cycle: the byte is processed first; the resulting access runs as drained, then -> IDLE.
- frame_start while draining: ignored; the block returns to IDLE, so that frame is not served (busy is visible).
- A CMD-only frame (no data bytes) generates no bus access.
- rst mid-access: reg_req drops asynchronously; no completion is required.

Decomposition:
- Package spi_reg_pkg holds:
  - state enum (IDLE, CMD, RD_REQ, WR_REQ, DATA);
  - CMD_RW_BIT = 7;
  - DUMMY_BYTE = 8'hFF;
  - timeout counter width = 8.
- Sub-module spi_frame_det: cs 2-flop synchroniser plus rising/falling edge pulses; reused by later SPI-side blocks.

Test Plan:
- Write burst: cs low, bytes 0x05, 0xA1, 0xB2, ack after 2 cycles -> writes (0x05, 0xA1) then (0x06, 0xB2); err = 0; IDLE after cs high.
- Read burst: bytes 0x90, 0x00, 0x00, rdata = addr + 0x40 -> reads 0x10, 0x11, 0x12; tx_data = 0x50 then 0x51; tx_ready = 1 until frame_end.
- Wrap + AUTO_INC = 0 instance: write at 0x7F with two data bytes -> addresses 0x7F, 0x00; the AUTO_INC = 0 instance writes 0x7F twice.
- Timeout: read 0x83, reg_ack tied 0 -> reg_req high exactly 15 cycles; tx_data = 0xFF; err = 1 and stays set across the next frame.
- Abort: cs rises during WR_REQ, ack 5 cycles later -> write completes; then IDLE, busy = 0; a frame_start during draining produces no access.
- Overrun + async reset: rx_valid during a stalled RD_REQ -> err = 1, access unchanged; rst pulse mid-access -> reg_req = 0 immediately, tx_data = 0xFF.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-access controller.
// Imported by the controller and by later SPI-side blocks.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD_REQ,
    WR_REQ,
    DATA
  } state_t;

  localparam int         CMD_RW_BIT = 7;
  localparam logic [7:0] DUMMY_BYTE = 8'hFF;
  localparam int         TCNT_W     = 8;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Single-master 8-bit register bus with req/ack handshake.
// The controller uses the master modport and the register file uses the slave modport.
interface spi_reg_ctrl_if #(
  parameter int ADDR_W = 7
);

  logic              reg_req;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic [7:0]        reg_rdata;
  logic              reg_ack;

  modport master (
    output reg_req, reg_we, reg_addr, reg_wdata,
    input  reg_rdata, reg_ack
  );

  modport slave (
    input  reg_req, reg_we, reg_addr, reg_wdata,
    output reg_rdata, reg_ack
  );

endinterface

// File: rtl/spi_frame_det.sv
// Chip-select synchroniser with one-cycle frame start/end pulses.
// cs is active low, so a falling edge opens a frame and a rising edge closes it.
module spi_frame_det (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  output logic frame_start,
  output logic frame_end
);

  logic cs_meta;
  logic cs_sync;
  logic cs_d;

  // Idle level is high, so a reset never looks like a frame edge.
  // NOTE: every flop here is updated with <=; blocking assignments would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_meta <= 1'b1;
      cs_sync <= 1'b1;
      cs_d    <= 1'b1;
    end else begin
      cs_meta <= cs;
      cs_sync <= cs_meta;
      cs_d    <= cs_sync;
    end
  end

  assign frame_start = cs_d & ~cs_sync;
  assign frame_end   = ~cs_d & cs_sync;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Turns SPI command and data bytes into register bus reads and writes.
// Read data goes back to the SPI transmit path, and a bus timeout aborts a stalled access.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         ADDR_W   = 7,
  parameter int         AUTO_INC = 1,
  parameter int         TIMEOUT  = 15,
  parameter logic [7:0] DUMMY    = DUMMY_BYTE
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cs,
  input  logic           rx_valid,
  input  logic [7:0]     rx_data,
  output logic           tx_ready,
  output logic [7:0]     tx_data,
  spi_reg_ctrl_if.master bus,
  output logic           busy,
  output logic           err
);

  state_t              state;
  state_t              state_next;
  logic                frame_start;
  logic                frame_end;
  logic                rw;
  logic                drain;
  logic [ADDR_W-1:0]   addr;
  logic [7:0]          wdata;
  logic [TCNT_W-1:0]   tcnt;
  logic                in_req;
  logic                timeout_hit;
  logic                done;
  logic                ending;

  spi_frame_det u_frame_det (
    .clk         (clk),
    .rst         (rst),
    .cs          (cs),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  assign in_req      = (state == RD_REQ) || (state == WR_REQ);
  assign timeout_hit = in_req && !bus.reg_ack && (tcnt == TCNT_W'(TIMEOUT - 1));
  assign done        = in_req && (bus.reg_ack || timeout_hit);
  // A frame that closed while the access was in flight makes the completion end in IDLE.
  assign ending      = drain || frame_end;

  assign bus.reg_req   = in_req;
  assign bus.reg_we    = (state == WR_REQ);
  assign bus.reg_addr  = addr;
  assign bus.reg_wdata = wdata;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets its default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (frame_start) state_next = CMD;
      end
      CMD: begin
        if (rx_valid) begin
          if (rx_data[CMD_RW_BIT]) state_next = RD_REQ;
          else if (frame_end)      state_next = IDLE;
          else                     state_next = DATA;
        end else if (frame_end) begin
          state_next = IDLE;
        end
      end
      DATA: begin
        if (rx_valid)       state_next = rw ? RD_REQ : WR_REQ;
        else if (frame_end) state_next = IDLE;
      end
      RD_REQ, WR_REQ: begin
        if (done) state_next = ending ? IDLE : DATA;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw       <= 1'b0;
      drain    <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      tcnt     <= '0;
      tx_data  <= DUMMY;
      tx_ready <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (state == CMD && rx_valid) begin
        rw   <= rx_data[CMD_RW_BIT];
        addr <= rx_data[ADDR_W-1:0];
      end

      if (state == DATA && rx_valid && !rw) wdata <= rx_data;

      // The counter holds at zero outside an access, so it restarts on every entry.
      if (!in_req)           tcnt <= '0;
      else if (!bus.reg_ack) tcnt <= tcnt + TCNT_W'(1);

      // An overrun byte is dropped, but it still marks the sticky error.
      if ((in_req && rx_valid) || timeout_hit) err <= 1'b1;

      if (state_next == IDLE) drain <= 1'b0;
      else if (frame_end)     drain <= 1'b1;

      if (done) begin
        if (AUTO_INC != 0) addr <= addr + ADDR_W'(1);
        if (state == RD_REQ && !ending) begin
          tx_data  <= bus.reg_ack ? bus.reg_rdata : DUMMY;
          tx_ready <= 1'b1;
        end
      end

      if (state_next == IDLE) begin
        tx_data  <= DUMMY;
        tx_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: a scoreboard of bus accesses, table-driven single-access frames,
// and directed multi-cycle sequences. A second instance has AUTO_INC = 0.
module tb_spi_reg_ctrl;

  typedef struct {
    bit         we;
    logic [6:0] addr;
    logic [7:0] wdata;
  } bus_op_t;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    bit         has_data;
    bit         exp_we;
    logic [6:0] exp_addr;
    logic [7:0] exp_tx;
    bit         exp_ready;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs  = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data  = 8'h00;

  logic       tx_ready0, busy0, err0;
  logic [7:0] tx_data0;
  logic       tx_ready1, busy1, err1;
  logic [7:0] tx_data1;

  int n_pass  = 0;
  int n_total = 0;

  int ack_en    = 1;
  int ack_delay = 0;
  int req_cyc   = 0;

  bus_op_t     exp_q[$];
  logic [14:0] log1[$];
  vec_t        vecs[5];

  spi_reg_ctrl_if #(.ADDR_W(7)) b0 ();
  spi_reg_ctrl_if #(.ADDR_W(7)) b1 ();

  spi_reg_ctrl #(.ADDR_W(7), .AUTO_INC(1), .TIMEOUT(15), .DUMMY(8'hFF)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_ready (tx_ready0),
    .tx_data  (tx_data0),
    .bus      (b0),
    .busy     (busy0),
    .err      (err0)
  );

  spi_reg_ctrl #(.ADDR_W(7), .AUTO_INC(0), .TIMEOUT(15), .DUMMY(8'hFF)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_ready (tx_ready1),
    .tx_data  (tx_data1),
    .bus      (b1),
    .busy     (busy1),
    .err      (err1)
  );

  always #5 clk = ~clk;

  // Register file model for dut0: programmable ack delay and rdata = addr + 0x40.
  always @(posedge clk) begin
    if (!b0.reg_req || b0.reg_ack) req_cyc <= 0;
    else                           req_cyc <= req_cyc + 1;
  end
  assign b0.reg_ack   = b0.reg_req && (ack_en != 0) && (req_cyc == ack_delay);
  assign b0.reg_rdata = {1'b0, b0.reg_addr} + 8'h40;

  // dut1 gets a zero-wait responder; its completed accesses are logged.
  assign b1.reg_ack   = b1.reg_req;
  assign b1.reg_rdata = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin : mon0
    bus_op_t e;
    if (!rst && b0.reg_req && b0.reg_ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected bus access", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("bus we", {31'd0, b0.reg_we}, {31'd0, e.we});
        check("bus addr", {25'd0, b0.reg_addr}, {25'd0, e.addr});
        if (e.we) check("bus wdata", {24'd0, b0.reg_wdata}, {24'd0, e.wdata});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b1.reg_req && b1.reg_ack) log1.push_back({b1.reg_addr, b1.reg_wdata});
  end

  task automatic push_op(input bit we, input logic [6:0] addr, input logic [7:0] wdata);
    bus_op_t op;
    op.we    = we;
    op.addr  = addr;
    op.wdata = wdata;
    exp_q.push_back(op);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    cs = 1'b1;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic wait_bus();
    int n = 0;
    while (b0.reg_req && n < 60) begin
      tick(1);
      n++;
    end
    if (b0.reg_req) check("bus wait bound", 32'd1, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0] = '{cmd: 8'h05, data: 8'hA1, has_data: 1'b1, exp_we: 1'b1, exp_addr: 7'h05, exp_tx: 8'hFF, exp_ready: 1'b0};
    vecs[1] = '{cmd: 8'h7F, data: 8'h3C, has_data: 1'b1, exp_we: 1'b1, exp_addr: 7'h7F, exp_tx: 8'hFF, exp_ready: 1'b0};
    vecs[2] = '{cmd: 8'h90, data: 8'h00, has_data: 1'b0, exp_we: 1'b0, exp_addr: 7'h10, exp_tx: 8'h50, exp_ready: 1'b1};
    vecs[3] = '{cmd: 8'hFF, data: 8'h00, has_data: 1'b0, exp_we: 1'b0, exp_addr: 7'h7F, exp_tx: 8'hBF, exp_ready: 1'b1};
    vecs[4] = '{cmd: 8'h80, data: 8'h00, has_data: 1'b0, exp_we: 1'b0, exp_addr: 7'h00, exp_tx: 8'h40, exp_ready: 1'b1};

    // Reset values.
    #12;
    check("reset tx_data", {24'd0, tx_data0}, 32'hFF);
    check("reset tx_ready", {31'd0, tx_ready0}, 32'd0);
    check("reset reg_req", {31'd0, b0.reg_req}, 32'd0);
    check("reset busy", {31'd0, busy0}, 32'd0);
    check("reset err", {31'd0, err0}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(2);

    // Single-access frames, zero-wait ack.
    ack_delay = 0;
    foreach (vecs[i]) begin
      push_op(vecs[i].exp_we, vecs[i].exp_addr, vecs[i].data);
      cs_low();
      send_byte(vecs[i].cmd);
      wait_bus();
      if (vecs[i].has_data) begin
        send_byte(vecs[i].data);
        wait_bus();
      end
      check($sformatf("vec%0d tx_data", i), {24'd0, tx_data0}, {24'd0, vecs[i].exp_tx});
      check($sformatf("vec%0d tx_ready", i), {31'd0, tx_ready0}, {31'd0, vecs[i].exp_ready});
      cs_high();
      check($sformatf("vec%0d busy", i), {31'd0, busy0}, 32'd0);
    end

    // Write burst with delayed ack.
    ack_delay = 2;
    push_op(1'b1, 7'h05, 8'hA1);
    push_op(1'b1, 7'h06, 8'hB2);
    cs_low();
    send_byte(8'h05);
    send_byte(8'hA1);
    wait_bus();
    send_byte(8'hB2);
    wait_bus();
    check("wr burst err", {31'd0, err0}, 32'd0);
    cs_high();
    check("wr burst busy", {31'd0, busy0}, 32'd0);

    // Read burst with prefetch.
    ack_delay = 0;
    push_op(1'b0, 7'h10, 8'h00);
    push_op(1'b0, 7'h11, 8'h00);
    push_op(1'b0, 7'h12, 8'h00);
    cs_low();
    send_byte(8'h90);
    wait_bus();
    check("rd burst tx0", {24'd0, tx_data0}, 32'h50);
    check("rd burst ready0", {31'd0, tx_ready0}, 32'd1);
    send_byte(8'h00);
    wait_bus();
    check("rd burst tx1", {24'd0, tx_data0}, 32'h51);
    send_byte(8'h00);
    wait_bus();
    check("rd burst tx2", {24'd0, tx_data0}, 32'h52);
    check("rd burst ready2", {31'd0, tx_ready0}, 32'd1);
    cs_high();
    check("rd end ready", {31'd0, tx_ready0}, 32'd0);
    check("rd end tx_data", {24'd0, tx_data0}, 32'hFF);

    // Address wrap, and the fixed address on the AUTO_INC = 0 instance.
    log1.delete();
    push_op(1'b1, 7'h7F, 8'h11);
    push_op(1'b1, 7'h00, 8'h22);
    cs_low();
    send_byte(8'h7F);
    send_byte(8'h11);
    wait_bus();
    send_byte(8'h22);
    wait_bus();
    cs_high();
    check("wrap err", {31'd0, err0}, 32'd0);
    check("no-inc access count", log1.size(), 32'd2);
    if (log1.size() >= 2) begin
      check("no-inc access0", {17'd0, log1[0]}, {17'd0, 7'h7F, 8'h11});
      check("no-inc access1", {17'd0, log1[1]}, {17'd0, 7'h7F, 8'h22});
    end

    // Frame closes mid-write: the write completes, and a new frame during draining is not served.
    ack_delay = 8;
    push_op(1'b1, 7'h20, 8'h77);
    cs_low();
    send_byte(8'h20);
    send_byte(8'h77);
    cs = 1'b1;
    tick(3);
    cs = 1'b0;
    wait_bus();
    tick(4);
    check("drain busy", {31'd0, busy0}, 32'd0);
    check("drain tx_data", {24'd0, tx_data0}, 32'hFF);
    send_byte(8'h45);
    tick(3);
    check("ignored frame req", {31'd0, b0.reg_req}, 32'd0);
    check("ignored frame busy", {31'd0, busy0}, 32'd0);
    cs_high();

    // Overrun during a stalled read.
    ack_delay = 10;
    push_op(1'b0, 7'h30, 8'h00);
    cs_low();
    send_byte(8'hB0);
    tick(2);
    send_byte(8'h99);
    check("overrun err", {31'd0, err0}, 32'd1);
    check("overrun req", {31'd0, b0.reg_req}, 32'd1);
    check("overrun we", {31'd0, b0.reg_we}, 32'd0);
    check("overrun addr", {25'd0, b0.reg_addr}, 32'h30);
    wait_bus();
    check("overrun tx_data", {24'd0, tx_data0}, 32'h70);
    cs_high();

    // Asynchronous reset in the middle of an access.
    ack_en = 0;
    cs_low();
    send_byte(8'h84);
    tick(3);
    check("pre-reset req", {31'd0, b0.reg_req}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("async reset req", {31'd0, b0.reg_req}, 32'd0);
    check("async reset tx_data", {24'd0, tx_data0}, 32'hFF);
    check("async reset busy", {31'd0, busy0}, 32'd0);
    check("async reset err", {31'd0, err0}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(4);
    cs_high();

    // Timeout on a read with ack tied low.
    ack_en = 0;
    cs_low();
    send_byte(8'h83);
    n = 0;
    while (b0.reg_req && n < 40) begin
      n++;
      tick(1);
    end
    check("timeout req cycles", n, 32'd15);
    check("timeout tx_data", {24'd0, tx_data0}, 32'hFF);
    check("timeout tx_ready", {31'd0, tx_ready0}, 32'd1);
    check("timeout err", {31'd0, err0}, 32'd1);
    ack_en = 1;
    ack_delay = 0;
    cs_high();
    push_op(1'b1, 7'h01, 8'h55);
    cs_low();
    send_byte(8'h01);
    send_byte(8'h55);
    wait_bus();
    cs_high();
    check("err sticky", {31'd0, err0}, 32'd1);

    tick(2);
    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
